mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the pipeline: the consumer of the Execute/Memory pipeline register's outputs. It issues loads and stores to the data cache, waits out misses, and drives the `stall` input of that register. It also aligns and extends load data and registers the completed result, ROB id and exception flag toward writeback/ROB.

## Interface
Parameters:
- WORD_SIZE, 32, data/address width (fixed at 32 for the RV32 byte-lane logic)
- ROB_ID_W, 7, ROB identifier width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- instruction_type  in  2  from E/M register; 0 ALU, 1 load, 2 store, 3 other (pass-through)
- pc  in  WORD_SIZE  instruction PC
- funct3  in  3  load/store width: 0 B, 1 H, 2 W, 4 BU, 5 HU
- aluResult  in  WORD_SIZE  effective address (load/store) or result (ALU/other)
- s2  in  WORD_SIZE  store data
- rob_id  in  ROB_ID_W  ROB tag
- valid  in  1  E/M register holds a live instruction
- stall  out  1  hold E/M register (combinational)
- dc_req  out  1  cache request (combinational)
- dc_we  out  1  1 store, 0 load
- dc_addr  out  WORD_SIZE  {aluResult[31:2], 2'b00}
- dc_wdata  out  WORD_SIZE  lane-replicated store data
- dc_be  out  4  byte enables
- dc_rdata  in  WORD_SIZE  aligned read word, valid when dc_ack
- dc_ack  in  1  request completed this cycle (hit same cycle, or fill done)
- wb_valid  out  1  registered: completed instruction
- wb_rob_id  out  ROB_ID_W  registered
- wb_pc  out  WORD_SIZE  registered
- wb_result  out  WORD_SIZE  registered
- wb_exc  out  1  registered: misaligned access
- stall_cycles  out  32  saturating count of cycles with stall=1

## Operation
- mem_op = valid & (instruction_type==1 | instruction_type==2).
- Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0. Misaligned mem_op issues no dc_req and completes immediately with wb_exc=1, wb_result=0.
- dc_req = mem_op & ~misaligned. stall = dc_req & ~dc_ack.
- Store: B -> dc_wdata={4{s2[7:0]}}, dc_be=1<<addr[1:0]; H -> {2{s2[15:0]}}, dc_be=3<<addr[1:0]; W -> s2, dc_be=4'hF. Load: dc_be=0.
- Load extract by addr[1:0]: B/H sign-extend; BU/HU zero-extend; W full word.
- wb_result: ALU/other -> aluResult; load -> extended data; store -> 0.
- FSM states:
  - IDLE -> WAIT when dc_req & ~dc_ack.
  - WAIT -> IDLE when dc_ack.
  - WAIT -> IDLE when valid drops (request abandoned).
  - In WAIT, the inputs are held by the E/M register, so dc_req is held with identical addr/data.
- stall_cycles increments each cycle stall=1 and saturates at 32'hFFFF_FFFF.

## Timing
- Completion cycle: valid & (~mem_op | misaligned | dc_ack). On the next rising edge, wb_valid<=1 and wb_* capture the values. Otherwise wb_valid<=0 and the other wb_* hold.
- Latency: a hit or non-mem instruction appears on wb_* one cycle after it is presented; a miss of N wait cycles appears N+1 cycles later.
- A valid instruction retires at most one per cycle; back-to-back hits produce wb_valid every cycle.
- dc_ack while dc_req=0 is ignored.
- Reset (async, any state, including mid-WAIT):
  - state=IDLE; wb_valid=0, wb_exc=0, wb_rob_id=0, wb_pc=0, wb_result=0, stall_cycles=0.
  - dc_req/stall follow inputs combinationally; the E/M register clears valid on reset, so both go 0.

## Test plan
- ALU pass-through: type=0, aluResult=7, rob_id=2, valid=1 -> stall=0, dc_req=0; next edge wb_valid=1, wb_result=7, wb_rob_id=2.
- Load hit LB: type=1, funct3=0, aluResult=0x1001, dc_ack=1 same cycle, dc_rdata=0x0000_8000 -> dc_addr=0x1000, stall=0; next edge wb_result=0xFFFF_FF80. Same with funct3=4 -> 0x0000_0080.
- Store miss SH: type=2, funct3=1, aluResult=0x2002, s2=0xABCD, dc_ack low 3 cycles then high:
  - dc_be=4'hC, dc_wdata=0xABCD_ABCD.
  - stall=1 for exactly 3 cycles; wb_valid pulses once, 4 edges after issue.
  - stall_cycles=3.
- Misaligned LW: type=1, funct3=2, aluResult=0x3003 -> dc_req=0, stall=0; next edge wb_valid=1, wb_exc=1, wb_result=0.
- Reset mid-miss: load, dc_ack=0 for 2 cycles, assert reset (valid drops) -> state IDLE; wb_valid=0, stall_cycles=0 immediately. After reset release, a new ALU op completes normally.
- Bubble: valid=0, type=1 -> dc_req=0, stall=0, wb_valid=0 on next edge; wb_result unchanged.

Source files
------------

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory stage - data-cache access, miss stall,
//               load alignment/extension and registered writeback result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int WORD_SIZE = 32,
    parameter int ROB_ID_W  = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           instruction_type,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic [2:0]           funct3,
    input  logic [WORD_SIZE-1:0] aluResult,
    input  logic [WORD_SIZE-1:0] s2,
    input  logic [ROB_ID_W-1:0]  rob_id,
    input  logic                 valid,
    output logic                 stall,
    output logic                 dc_req,
    output logic                 dc_we,
    output logic [WORD_SIZE-1:0] dc_addr,
    output logic [WORD_SIZE-1:0] dc_wdata,
    output logic [3:0]           dc_be,
    input  logic [WORD_SIZE-1:0] dc_rdata,
    input  logic                 dc_ack,
    output logic                 wb_valid,
    output logic [ROB_ID_W-1:0]  wb_rob_id,
    output logic [WORD_SIZE-1:0] wb_pc,
    output logic [WORD_SIZE-1:0] wb_result,
    output logic                 wb_exc,
    output logic [31:0]          stall_cycles
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [ROB_ID_W-1:0]    wb_rob_id_q, wb_rob_id_d;
    logic [WORD_SIZE-1:0]   wb_pc_q, wb_pc_d;
    logic [WORD_SIZE-1:0]   wb_result_q, wb_result_d;
    logic                   wb_exc_q, wb_exc_d;
    logic [31:0]            stall_cnt_q, stall_cnt_d;

    logic                   w_mem_op;
    logic                   w_is_store;
    logic                   w_mis_addr;
    logic                   w_misaligned;
    logic                   w_req;
    logic                   w_stall;
    logic                   w_complete;
    logic [1:0]             w_off;
    logic [WORD_SIZE-1:0]   w_byte_sh;
    logic [WORD_SIZE-1:0]   w_half_sh;
    logic [WORD_SIZE-1:0]   w_load_data;
    logic [WORD_SIZE-1:0]   w_wdata;
    logic [3:0]             w_be;

    always_comb begin
        w_off        = aluResult[1:0];
        w_is_store   = (instruction_type == 2'd2);
        w_mem_op     = valid && ((instruction_type == 2'd1) || w_is_store);

        case (funct3)
            3'd1, 3'd5: w_mis_addr = w_off[0];
            3'd2:       w_mis_addr = |w_off;
            default:    w_mis_addr = 1'b0;
        endcase

        w_misaligned = w_mem_op && w_mis_addr;
        w_req        = w_mem_op && !w_mis_addr;
        w_stall      = w_req && !dc_ack;
        w_complete   = valid && (!w_mem_op || w_misaligned || dc_ack);

        // Bring the addressed lane down to bit 0 before extension
        w_byte_sh = dc_rdata >> {w_off, 3'b000};
        w_half_sh = dc_rdata >> {w_off[1], 4'b0000};
        case (funct3)
            3'd0:    w_load_data = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
            3'd1:    w_load_data = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
            3'd4:    w_load_data = {24'd0, w_byte_sh[7:0]};
            3'd5:    w_load_data = {16'd0, w_half_sh[15:0]};
            default: w_load_data = dc_rdata;
        endcase

        case (funct3[1:0])
            2'd0: begin
                w_wdata = {4{s2[7:0]}};
                w_be    = 4'b0001 << w_off;
            end
            2'd1: begin
                w_wdata = {2{s2[15:0]}};
                w_be    = 4'b0011 << w_off;
            end
            default: begin
                w_wdata = s2;
                w_be    = 4'hF;
            end
        endcase
        if (!w_is_store) begin
            w_be = 4'h0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_req && !dc_ack) state_d = ST_WAIT;
            ST_WAIT: if (!w_req || dc_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        wb_valid_d  = w_complete;
        wb_rob_id_d = wb_rob_id_q;
        wb_pc_d     = wb_pc_q;
        wb_result_d = wb_result_q;
        wb_exc_d    = wb_exc_q;
        if (w_complete) begin
            wb_rob_id_d = rob_id;
            wb_pc_d     = pc;
            wb_exc_d    = w_misaligned;
            if (w_misaligned || w_is_store) begin
                wb_result_d = '0;
            end else if (w_mem_op) begin
                wb_result_d = w_load_data;
            end else begin
                wb_result_d = aluResult;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (w_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wb_valid_q  <= 1'b0;
            wb_rob_id_q <= '0;
            wb_pc_q     <= '0;
            wb_result_q <= '0;
            wb_exc_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= wb_valid_d;
            wb_rob_id_q <= wb_rob_id_d;
            wb_pc_q     <= wb_pc_d;
            wb_result_q <= wb_result_d;
            wb_exc_q    <= wb_exc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall        = w_stall;
    assign dc_req       = w_req;
    assign dc_we        = w_is_store;
    assign dc_addr      = {aluResult[WORD_SIZE-1:2], 2'b00};
    assign dc_wdata     = w_wdata;
    assign dc_be        = w_be;
    assign wb_valid     = wb_valid_q;
    assign wb_rob_id    = wb_rob_id_q;
    assign wb_pc        = wb_pc_q;
    assign wb_result    = wb_result_q;
    assign wb_exc       = wb_exc_q;
    assign stall_cycles = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic [1:0]  itype;
    logic [31:0] pc;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [31:0] s2;
    logic [6:0]  rob_id;
    logic        valid;
    logic        stall;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_be;
    logic [31:0] dc_rdata;
    logic        dc_ack;
    logic        wb_valid;
    logic [6:0]  wb_rob_id;
    logic [31:0] wb_pc;
    logic [31:0] wb_result;
    logic        wb_exc;
    logic [31:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the registered outputs
    logic        m_valid;
    logic [6:0]  m_rob;
    logic [31:0] m_pc;
    logic [31:0] m_res;
    logic        m_exc;
    logic [31:0] m_cnt;

    mem_stage #(.WORD_SIZE(32), .ROB_ID_W(7)) dut (
        .clk(clk), .reset(reset), .instruction_type(itype), .pc(pc),
        .funct3(funct3), .aluResult(alu), .s2(s2), .rob_id(rob_id),
        .valid(valid), .stall(stall), .dc_req(dc_req), .dc_we(dc_we),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_be(dc_be),
        .dc_rdata(dc_rdata), .dc_ack(dc_ack), .wb_valid(wb_valid),
        .wb_rob_id(wb_rob_id), .wb_pc(wb_pc), .wb_result(wb_result),
        .wb_exc(wb_exc), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_memop();
        return valid && (itype == 2'd1 || itype == 2'd2);
    endfunction

    function automatic logic m_mis();
        int off = int'(alu[1:0]);
        if (!m_memop()) return 1'b0;
        if ((funct3 == 3'd1 || funct3 == 3'd5) && (off % 2 != 0)) return 1'b1;
        if (funct3 == 3'd2 && off != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_req();
        return m_memop() && !m_mis();
    endfunction

    function automatic logic [31:0] m_load();
        logic [31:0] b, h;
        b = (dc_rdata >> (8 * alu[1:0])) & 32'hFF;
        h = (dc_rdata >> (8 * alu[1:0])) & 32'hFFFF;
        case (funct3)
            3'd0:    return (b ^ 32'h80) - 32'h80;
            3'd1:    return (h ^ 32'h8000) - 32'h8000;
            3'd4:    return b;
            3'd5:    return h;
            default: return dc_rdata;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rob = 0; m_pc = 0; m_res = 0; m_exc = 0; m_cnt = 0;
    endtask

    // One clock: check every output at the falling edge, advance the model,
    // and return just after the following rising edge.
    task automatic step();
        logic        e_req, e_stall, e_done;
        logic [31:0] e_be, e_wd;
        @(negedge clk);
        e_req   = m_req();
        e_stall = e_req && !dc_ack;
        chk("dc_req", dc_req, e_req);
        chk("stall", stall, e_stall);
        if (e_req) begin
            chk("dc_we", dc_we, itype == 2'd2);
            chk("dc_addr", dc_addr, alu & 32'hFFFF_FFFC);
            if (itype == 2'd2) begin
                case (funct3)
                    3'd0: begin e_wd = s2[7:0] * 32'h0101_0101; e_be = 32'd1 << alu[1:0]; end
                    3'd1: begin e_wd = s2[15:0] * 32'h0001_0001; e_be = 32'd3 << alu[1:0]; end
                    default: begin e_wd = s2; e_be = 32'hF; end
                endcase
                chk("dc_wdata", dc_wdata, e_wd);
                chk("dc_be", dc_be, e_be);
            end else begin
                chk("dc_be_load", dc_be, 0);
            end
        end
        chk("wb_valid", wb_valid, m_valid);
        chk("wb_rob_id", wb_rob_id, m_rob);
        chk("wb_pc", wb_pc, m_pc);
        chk("wb_result", wb_result, m_res);
        chk("wb_exc", wb_exc, m_exc);
        chk("stall_cycles", stall_cycles, m_cnt);
        if (reset) begin
            model_reset();
        end else begin
            e_done = valid && (!m_memop() || m_mis() || dc_ack);
            m_valid = e_done;
            if (e_done) begin
                m_rob = rob_id;
                m_pc  = pc;
                m_exc = m_mis();
                if (m_mis() || itype == 2'd2) m_res = 0;
                else if (itype == 2'd1)       m_res = m_load();
                else                          m_res = alu;
            end
            if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] t, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [6:0] r, input logic v);
        itype = t; funct3 = f3; alu = a; s2 = d; rob_id = r; valid = v;
        pc = 32'h0000_4000 + {25'd0, r} * 4;
    endtask

    int  miss;
    logic holding;

    task automatic gen_instr();
        logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [1:0] t;
        t        = 2'($urandom_range(0, 3));
        itype    = t;
        funct3   = (t == 2'd2) ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
        alu      = $urandom;
        s2       = $urandom;
        rob_id   = 7'($urandom);
        pc       = $urandom;
        dc_rdata = $urandom;
        valid    = ($urandom_range(0, 7) != 0);
        miss     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endtask

    initial begin
        reset = 1'b1; dc_ack = 1'b0; dc_rdata = 0;
        set_op(2'd0, 3'd0, 0, 0, 0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_result", wb_result, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        step();
        reset = 1'b0;

        // ALU pass-through
        set_op(2'd0, 3'd0, 32'd7, 0, 7'd2, 1'b1);
        step();
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_result", wb_result, 32'd7);
        chk("alu_wb_rob", wb_rob_id, 32'd2);

        // LB / LBU hit
        set_op(2'd1, 3'd0, 32'h1001, 0, 7'd3, 1'b1);
        dc_ack = 1'b1; dc_rdata = 32'h0000_8000;
        step();
        chk("lb_addr", dc_addr, 32'h1000);
        chk("lb_stall", stall, 0);
        chk("lb_result", wb_result, 32'hFFFF_FF80);
        funct3 = 3'd4;
        step();
        chk("lbu_result", wb_result, 32'h0000_0080);

        // Bubble holds the previous result
        valid = 1'b0; itype = 2'd1; dc_ack = 1'b0;
        step();
        chk("bub_wb_valid", wb_valid, 0);
        chk("bub_wb_result", wb_result, 32'h0000_0080);

        // SH miss, three wait cycles
        set_op(2'd2, 3'd1, 32'h2002, 32'h0000_ABCD, 7'd4, 1'b1);
        dc_ack = 1'b0;
        #1;
        chk("sh_be", dc_be, 32'hC);
        chk("sh_wdata", dc_wdata, 32'hABCD_ABCD);
        chk("sh_stall", stall, 1);
        for (int i = 0; i < 3; i++) step();
        dc_ack = 1'b1;
        step();
        chk("sh_wb_valid", wb_valid, 1);
        chk("sh_stall_cycles", stall_cycles, 32'd3);

        // Misaligned LW
        set_op(2'd1, 3'd2, 32'h3003, 0, 7'd5, 1'b1);
        dc_ack = 1'b0;
        step();
        chk("mis_req", dc_req, 0);
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_wb_exc", wb_exc, 1);
        chk("mis_wb_result", wb_result, 0);

        // Reset in the middle of a miss
        set_op(2'd1, 3'd2, 32'h0000_0040, 0, 7'd6, 1'b1);
        dc_ack = 1'b0;
        step();
        step();
        reset = 1'b1; valid = 1'b0;
        #1;
        chk("mrst_wb_valid", wb_valid, 0);
        chk("mrst_stall_cycles", stall_cycles, 0);
        chk("mrst_stall", stall, 0);
        model_reset();
        step();
        reset = 1'b0;
        set_op(2'd0, 3'd0, 32'h1234_5678, 0, 7'd9, 1'b1);
        step();
        chk("post_rst_valid", wb_valid, 1);
        chk("post_rst_result", wb_result, 32'h1234_5678);

        // Randomised traffic with miss latencies and occasional abandonment
        holding = 1'b0;
        miss = 0;
        for (int k = 0; k < 3000; k++) begin
            if (holding) begin
                if ($urandom_range(0, 15) == 0) valid = 1'b0;
            end else begin
                gen_instr();
            end
            if (m_req()) dc_ack = (miss == 0);
            else         dc_ack = 1'($urandom);
            holding = m_req() && !dc_ack;
            step();
            if (holding) miss--;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
